// File: rtl/gemm_issue_queue.sv
// In-order GEMM issue queue with a matrix-register scoreboard that blocks RAW/WAW hazards.
// Optional same-cycle bypass into an empty queue when GEMM_IQ_BYPASS_EN is defined.
module gemm_issue_queue #(
    parameter int REG_W = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic [REG_W-1:0] in_rs3,
    input  logic [REG_W-1:0] in_rd,
    output logic             in_ready,
    input  logic             flush,
    input  logic             freeze,
    output logic             out_valid,
    output logic [REG_W-1:0] out_rs1,
    output logic [REG_W-1:0] out_rs2,
    output logic [REG_W-1:0] out_rs3,
    output logic [REG_W-1:0] out_rd,
    input  logic             out_ready,
    input  logic             done_valid,
    input  logic [REG_W-1:0] done_rd,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int NREG  = 1 << REG_W;

    logic [REG_W-1:0] q_rs1 [DEPTH];
    logic [REG_W-1:0] q_rs2 [DEPTH];
    logic [REG_W-1:0] q_rs3 [DEPTH];
    logic [REG_W-1:0] q_rd  [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [NREG-1:0]  busy, busy_nxt;
    logic             full, empty, hazard;
    logic             issue, push, pop, bypass;
    logic [REG_W-1:0] head_rs1, head_rs2, head_rs3, head_rd;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full && !freeze && !flush;

    assign head_rs1 = empty ? '0 : q_rs1[rd_ptr];
    assign head_rs2 = empty ? '0 : q_rs2[rd_ptr];
    assign head_rs3 = empty ? '0 : q_rs3[rd_ptr];
    assign head_rd  = empty ? '0 : q_rd[rd_ptr];

    assign hazard = busy[head_rs1] | busy[head_rs2] | busy[head_rs3] | busy[head_rd];

`ifdef GEMM_IQ_BYPASS_EN
    logic in_hazard;
    assign in_hazard = busy[in_rs1] | busy[in_rs2] | busy[in_rs3] | busy[in_rd];
`endif

    always_comb begin
        out_valid    = !empty && !hazard && !freeze && !flush;
        out_rs1      = head_rs1;
        out_rs2      = head_rs2;
        out_rs3      = head_rs3;
        out_rd       = head_rd;
        hazard_stall = !empty && hazard && !freeze;
        bypass       = 1'b0;
`ifdef GEMM_IQ_BYPASS_EN
        // Empty queue with a clean incoming op: hand it straight to the array.
        if (empty && in_valid && in_ready && out_ready && !in_hazard) begin
            bypass    = 1'b1;
            out_valid = 1'b1;
            out_rs1   = in_rs1;
            out_rs2   = in_rs2;
            out_rs3   = in_rs3;
            out_rd    = in_rd;
        end
`endif
    end

    assign issue = out_valid && out_ready;
    assign push  = in_valid && in_ready && !bypass;
    assign pop   = issue && !bypass;

    // Issue set is applied after done clear so it wins on the same index.
    always_comb begin
        busy_nxt = busy;
        if (done_valid) busy_nxt[done_rd] = 1'b0;
        if (issue)      busy_nxt[out_rd]  = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) busy <= '0;
        else       busy <= busy_nxt;
    end

    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            q_rs1[wr_ptr] <= in_rs1;
            q_rs2[wr_ptr] <= in_rs2;
            q_rs3[wr_ptr] <= in_rs3;
            q_rd[wr_ptr]  <= in_rd;
        end
    end
endmodule
